mux_n_pipe: RTL and testbench

- Parametrised, registered N:1 data selector with a valid/ready handshake on both sides. It generalises the single-cycle 16x1 combinational select used for writeback/operand muxing.
- Targets the pipelined core: width and input count are parameters.
- Out-of-range selects are defined: zero data plus an error flag, never X.
- A 2-entry skid buffer gives full throughput without a combinational ready path from output to input.

---
 rtl/mux_n_pipe_pkg.sv | 10 +
 rtl/skid_buf_2.sv | 56 +++++
 rtl/mux_n_pipe.sv | 47 ++++
 tb/tb_mux_n_pipe.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mux_n_pipe_pkg.sv
// mux_n_pipe_pkg: shared types and constants for the registered N:1 selector.
package mux_n_pipe_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int ERR_CNT_W = 16;
  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic err;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} count_e;
endpackage

// File: rtl/skid_buf_2.sv
// skid_buf_2: generic 2-entry valid/ready buffer; in_ready is a flop, so out_ready never reaches it combinationally.
module skid_buf_2 import mux_n_pipe_pkg::*; #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  count_e state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic in_xfer, out_xfer, ld_main, ld_skid, mv_skid;
  assign in_xfer = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign out_valid = state_q != EMPTY;
  assign out_data = main_q;
  always_comb begin
    state_d = state_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    case (state_q)
      EMPTY: if (in_xfer) begin
        ld_main = 1'b1;
        state_d = ONE;
      end
      ONE: if (in_xfer && out_xfer) ld_main = 1'b1;
      else if (in_xfer) begin
        ld_skid = 1'b1;
        state_d = FULL;
      end else if (out_xfer) state_d = EMPTY;
      FULL: if (out_xfer) begin
        mv_skid = 1'b1;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      in_ready <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready <= state_d != FULL;
      main_q <= ld_main ? in_data : mv_skid ? skid_q : main_q;
      skid_q <= ld_skid ? in_data : skid_q;
    end
  end
endmodule

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: registered N:1 selector with valid/ready on both sides; MUX_N_PIPE_ERR_CNT_EN adds a saturating error counter.
module mux_n_pipe import mux_n_pipe_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int NUM_IN = 11,
  parameter int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_N_PIPE_ERR_CNT_EN
  ,
  input  logic                    err_clr,
  output logic [ERR_CNT_W-1:0]    err_count
`endif
);
  logic [WIDTH-1:0] sel_data;
  logic sel_err;
  assign sel_err = {1'b0, in_sel} >= (SEL_W+1)'(NUM_IN);
  // Out-of-range selects match no input, so they yield zero rather than X.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) sel_data = in_sel == SEL_W'(k) ? in_data[k*WIDTH +: WIDTH] : sel_data;
  end
  skid_buf_2 #(.W(WIDTH + 1)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .in_data({sel_data, sel_err}),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data({out_data, out_err}),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );
`ifdef MUX_N_PIPE_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || err_clr) err_count <= '0;
    else if (out_valid && out_ready && out_err && err_count != '1) err_count <= err_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: directed plus random stimulus against a 2-deep FIFO reference model.
module tb_mux_n_pipe;
  localparam int WIDTH = 32;
  localparam int NUM_IN = 11;
  localparam int SEL_W = $clog2(NUM_IN);
  typedef struct {logic [WIDTH-1:0] d; logic e;} ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0] in_sel = '0;
  logic in_valid = 1'b0;
  logic in_ready, out_err, out_valid;
  logic out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] w [NUM_IN];
  ent_t q[$];
  int n_chk = 0;
  int n_err = 0;
`ifdef MUX_N_PIPE_ERR_CNT_EN
  logic err_clr = 1'b0;
  logic [15:0] err_count;
  int exp_cnt = 0;
`endif
  mux_n_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_sel(in_sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_err(out_err),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef MUX_N_PIPE_ERR_CNT_EN
    ,
    .err_clr(err_clr),
    .err_count(err_count)
`endif
  );
  always #5 clk = ~clk;
  always_comb for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = w[k];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    ent_t e;
    bit ix, ox;
    if (rst_n) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
        chk("out_data", 64'(out_data), 64'(q[0].d));
        chk("out_err", 64'(out_err), 64'(q[0].e));
      end
`ifdef MUX_N_PIPE_ERR_CNT_EN
      chk("err_count", 64'(err_count), 64'(exp_cnt));
`endif
    end
    ix = rst_n && in_valid && q.size() < 2;
    ox = rst_n && out_ready && q.size() > 0;
    e.e = int'(in_sel) >= NUM_IN;
    e.d = e.e ? '0 : w[in_sel];
`ifdef MUX_N_PIPE_ERR_CNT_EN
    if (!rst_n || err_clr) exp_cnt = 0;
    else if (ox && q[0].e && exp_cnt < 65535) exp_cnt++;
`endif
    @(posedge clk);
    if (!rst_n) q.delete();
    else begin
      if (ox) void'(q.pop_front());
      if (ix) q.push_back(e);
    end
    @(negedge clk);
  endtask
  initial begin
    for (int k = 0; k < NUM_IN; k++) w[k] = 32'h100 + k;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    in_sel = 4'd4; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_data", 64'(out_data), 64'h104);
    tick();
    tick();
    in_sel = 4'd13; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("oor_data", 64'(out_data), 64'd0);
    chk("oor_err", 64'(out_err), 64'd1);
    tick();
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 4'd1;
    tick();
    in_sel = 4'd2;
    tick();
    in_valid = 1'b0;
    chk("bp_ready", 64'(in_ready), 64'd0);
    chk("bp_hold", 64'(out_data), 64'h101);
    tick();
    tick();
    out_ready = 1'b1;
    repeat (3) tick();
    in_valid = 1'b1;
    for (int i = 0; i < 22; i++) begin
      in_sel = SEL_W'(i % NUM_IN);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 4'd7;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", 64'(out_data), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    repeat (3) tick();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NUM_IN; k++) w[k] = $urandom;
      in_sel = SEL_W'($urandom_range(0, 15));
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
`ifdef MUX_N_PIPE_ERR_CNT_EN
    in_sel = 4'd13; in_valid = 1'b1; out_ready = 1'b1;
    repeat (65540) tick();
    chk("cnt_sat", 64'(err_count), 64'hFFFF);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("cnt_clr", 64'(err_count), 64'd0);
    tick();
`endif
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
